// File: rtl/serial_cmd_ctrl.sv
// Serial command frame controller. Deserialises one LSB-first frame per CS assertion,
// runs the decoded read or write on a valid/ready bus, and shifts read data back out.
module serial_cmd_ctrl #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 32,
  parameter logic [7:0]  CMD_WR  = 8'hFF,
  parameter logic [7:0]  CMD_RD  = 8'h0F,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              miso,
  output logic              sdo,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              err_cmd,
  output logic              err_timeout,
  output logic              err_abort,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned FRAME_W = 8 + ADDR_W + DATA_W;
  localparam int unsigned CW      = $clog2(FRAME_W + 1);
  localparam int unsigned TW      = $clog2(TIMEOUT + 1);
  localparam int unsigned RW      = $clog2(DATA_W + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SHIFT  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] ISSUE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;

  logic [2:0]         state_q,     state_d;
  logic [FRAME_W-1:0] sr_q,        sr_d;
  logic [CW-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [TW-1:0]      tmo_q,       tmo_d;
  logic [RW-1:0]      rsp_q,       rsp_d;
  logic [DATA_W-1:0]  tx_q,        tx_d;
  logic               sdo_q,       sdo_d;
  logic               valid_q,     valid_d;
  logic               we_q,        we_d;
  logic [ADDR_W-1:0]  addr_q,      addr_d;
  logic [DATA_W-1:0]  wdata_q,     wdata_d;
  logic               err_cmd_q,   err_cmd_d;
  logic               err_tmo_q,   err_tmo_d;
  logic               err_abort_q, err_abort_d;
  logic [7:0]         fcnt_q,      fcnt_d;

  logic [7:0]         cmd;
  logic [DATA_W-1:0]  tx_shift;

  assign cmd      = sr_q[FRAME_W-1 -: 8];
  assign tx_shift = tx_q >> 1;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    rsp_d       = rsp_q;
    tx_d        = tx_q;
    sdo_d       = sdo_q;
    valid_d     = valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_cmd_d   = 1'b0;
    err_tmo_d   = 1'b0;
    err_abort_d = 1'b0;
    fcnt_d      = fcnt_q;
    case (state_q)
      IDLE: begin
        if (cs) begin
          sr_d      = {miso, sr_q[FRAME_W-1:1]};
          bit_cnt_d = CW'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!cs) begin
          err_abort_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else begin
          sr_d      = {miso, sr_q[FRAME_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(FRAME_W - 1)) state_d = DECODE;
        end
      end
      DECODE: begin
        bit_cnt_d = '0;
        if (cmd == CMD_WR || cmd == CMD_RD) begin
          addr_d  = sr_q[DATA_W +: ADDR_W];
          wdata_d = sr_q[DATA_W-1:0];
          we_d    = (cmd == CMD_WR);
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = ISSUE;
        end else begin
          err_cmd_d = 1'b1;
          state_d   = DRAIN;
        end
      end
      ISSUE: begin
        // cs is deliberately ignored here: an issued request always completes or times out
        if (bus_ready) begin
          valid_d = 1'b0;
          fcnt_d  = fcnt_q + 8'd1;
          if (we_q) begin
            state_d = DRAIN;
          end else begin
            tx_d    = bus_rdata;
            sdo_d   = bus_rdata[0];
            rsp_d   = '0;
            state_d = RESP;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          valid_d   = 1'b0;
          err_tmo_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        // sdo is registered one bit ahead so bit 0 appears the cycle after the handshake
        if (!cs) begin
          sdo_d   = 1'b0;
          state_d = IDLE;
        end else begin
          tx_d = tx_shift;
          if (rsp_q == RW'(DATA_W - 1)) begin
            sdo_d   = 1'b0;
            state_d = DRAIN;
          end else begin
            sdo_d = tx_shift[0];
            rsp_d = rsp_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!cs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      rsp_q       <= '0;
      tx_q        <= '0;
      sdo_q       <= 1'b0;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_cmd_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_abort_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      rsp_q       <= rsp_d;
      tx_q        <= tx_d;
      sdo_q       <= sdo_d;
      valid_q     <= valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_cmd_q   <= err_cmd_d;
      err_tmo_q   <= err_tmo_d;
      err_abort_q <= err_abort_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign sdo         = sdo_q;
  assign bus_valid   = valid_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign busy        = (state_q != IDLE);
  assign err_cmd     = err_cmd_q;
  assign err_timeout = err_tmo_q;
  assign err_abort   = err_abort_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Directed/randomised bench for serial_cmd_ctrl; expectations come from frame-level rules.
module tb_serial_cmd_ctrl;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cs = 1'b0;
  logic              miso = 1'b0;
  logic              bus_ready = 1'b0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              sdo, bus_valid, bus_we, busy, err_cmd, err_timeout, err_abort;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [7:0]        frame_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_fcnt = 0;

  always #5 clk = ~clk;

  serial_cmd_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CMD_WR (8'hFF),
    .CMD_RD (8'h0F),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .miso       (miso),
    .sdo        (sdo),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .busy       (busy),
    .err_cmd    (err_cmd),
    .err_timeout(err_timeout),
    .err_abort  (err_abort),
    .frame_cnt  (frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame is {cmd, addr, data}; bit i goes on the wire in cycle i
  function automatic logic [63:0] mk_frame(input logic [7:0] c, input logic [23:0] a,
                                           input logic [31:0] d);
    return {c, a, d};
  endfunction

  task automatic shift_bits(input logic [63:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      cs   = 1'b1;
      miso = f[i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs   = 1'b0;
    miso = 1'b0;
    @(negedge clk);
    chk("idle_after_cs_low", 64'(busy), 64'd0);
  endtask

  // Sends a valid-command frame and checks the request appears exactly two cycles later
  task automatic req(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
    shift_bits(mk_frame(c, a, d), 64);
    @(negedge clk);
    chk("valid_early", 64'(bus_valid), 64'd0);
    chk("busy_decode", 64'(busy), 64'd1);
    @(negedge clk);
    chk("valid_rise", 64'(bus_valid), 64'd1);
    chk("req_we",     64'(bus_we), 64'(c == 8'hFF));
    chk("req_addr",   64'(bus_addr), 64'(a));
    chk("req_wdata",  64'(bus_wdata), 64'(d));
  endtask

  task automatic hs(input int unsigned lat, input logic [23:0] a, input logic [31:0] d,
                    input logic [31:0] rd);
    for (int unsigned k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus_valid), 64'd1);
      chk("hold_addr",  64'(bus_addr), 64'(a));
      chk("hold_wdata", 64'(bus_wdata), 64'(d));
    end
    bus_ready = 1'b1;
    bus_rdata = rd;
    @(negedge clk);
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    exp_fcnt  = (exp_fcnt + 1) % 256;
    chk("valid_drop", 64'(bus_valid), 64'd0);
    chk("frame_cnt",  64'(frame_cnt), 64'(exp_fcnt));
  endtask

  task automatic do_write(input logic [23:0] a, input logic [31:0] d, input int unsigned lat);
    req(8'hFF, a, d);
    hs(lat, a, d, $urandom);
    chk("wr_sdo_zero", 64'(sdo), 64'd0);
    chk("wr_drain_busy", 64'(busy), 64'd1);
    end_frame();
  endtask

  task automatic do_read(input logic [23:0] a, input logic [31:0] d, input int unsigned lat,
                         input logic [31:0] rd);
    req(8'h0F, a, d);
    hs(lat, a, d, rd);
    for (int unsigned i = 0; i < DATA_W; i++) begin
      chk("sdo_bit", 64'(sdo), 64'(rd[i]));
      @(negedge clk);
    end
    chk("sdo_after", 64'(sdo), 64'd0);
    chk("rd_drain_busy", 64'(busy), 64'd1);
    end_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  c;
    logic [23:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    int unsigned cnt;

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_sdo",   64'(sdo), 64'd0);
    chk("rst_errs",  64'({err_cmd, err_timeout, err_abort}), 64'd0);
    chk("rst_fcnt",  64'(frame_cnt), 64'd0);
    chk("rst_bus",   64'({bus_we, bus_addr, bus_wdata}), 64'd0);
    rst_n = 1'b1;

    do_write(24'hABCDEF, 32'h12345678, 0);
    do_read(24'h000010, 32'h0, 3, 32'hDEADBEEF);

    for (int n = 0; n < 6; n++) begin
      a = 24'($urandom);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(a, d, $urandom_range(0, 5));
      else                           do_read(a, d, $urandom_range(0, 5), $urandom);
    end

    // Unknown commands: one err_cmd pulse, no request, then a normal frame
    for (int n = 0; n < 2; n++) begin
      c = (n == 0) ? 8'h55 : 8'($urandom);
      if (c == 8'hFF || c == 8'h0F) c = c ^ 8'h01;
      shift_bits(mk_frame(c, 24'($urandom), $urandom), 64);
      @(negedge clk);
      chk("errcmd_early", 64'(err_cmd), 64'd0);
      @(negedge clk);
      chk("errcmd_pulse", 64'(err_cmd), 64'd1);
      chk("errcmd_novalid", 64'(bus_valid), 64'd0);
      chk("errcmd_other", 64'({err_timeout, err_abort}), 64'd0);
      @(negedge clk);
      chk("errcmd_clear", 64'(err_cmd), 64'd0);
      chk("errcmd_novalid2", 64'(bus_valid), 64'd0);
      chk("errcmd_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
      end_frame();
      do_write(24'($urandom), $urandom, 1);
    end

    // Timeout with cs dropped mid-request
    a = 24'($urandom);
    d = $urandom;
    req(8'hFF, a, d);
    cnt = 0;
    do begin
      cnt++;
      if (cnt == 3) cs = 1'b0;
      @(negedge clk);
    end while (bus_valid && cnt < 100);
    chk("tmo_valid_cycles", 64'(cnt), 64'(TIMEOUT));
    chk("tmo_pulse", 64'(err_timeout), 64'd1);
    chk("tmo_fcnt", 64'(frame_cnt), 64'(exp_fcnt));
    @(negedge clk);
    chk("tmo_clear", 64'(err_timeout), 64'd0);
    chk("tmo_idle", 64'(busy), 64'd0);

    // Abort after 40 bits, then a clean frame
    shift_bits(mk_frame(8'hFF, 24'h5A5A5A, $urandom), 40);
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    chk("abort_pulse", 64'(err_abort), 64'd1);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_novalid", 64'(bus_valid), 64'd0);
    @(negedge clk);
    chk("abort_clear", 64'(err_abort), 64'd0);
    do_write(24'h123456, 32'hCAFEF00D, 0);

    // cs dropped during read response
    rd = $urandom;
    req(8'h0F, 24'h000777, 32'h0);
    hs(0, 24'h000777, 32'h0, rd);
    chk("resp_b0", 64'(sdo), 64'(rd[0]));
    @(negedge clk);
    chk("resp_b1", 64'(sdo), 64'(rd[1]));
    cs = 1'b0;
    @(negedge clk);
    chk("resp_stop_sdo", 64'(sdo), 64'd0);
    chk("resp_stop_idle", 64'(busy), 64'd0);

    // Asynchronous reset during ISSUE
    req(8'hFF, 24'h0000AA, 32'h55);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_fcnt", 64'(frame_cnt), 64'd0);
    cs = 1'b0;
    exp_fcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_novalid", 64'(bus_valid), 64'd0);

    for (int n = 0; n < 256; n++) do_write(24'($urandom), $urandom, 0);
    chk("fcnt_wrap", 64'(frame_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
